// File: rtl/spm_ctrl_pkg.sv
// Shared widths, core/bus direction encodings and the bus FSM state type.
package spm_ctrl_pkg;
  localparam int ADDR_W         = 30;
  localparam int DATA_W         = 32;
  localparam int DEPTH_LOG2_DEF = 12;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_ACK  = 2'd2
  } bus_state_t;
endpackage

// File: rtl/spm_ctrl_if.sv
// Core-side SPM port plus the req_/ack_ second-requester port.
interface spm_ctrl_if;
  import spm_ctrl_pkg::*;

  logic [ADDR_W-1:0] spm_addr;
  logic              spm_as_;
  logic              spm_rw;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] spm_rd_data;
  logic              spm_busy;
  logic              bus_req_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_ack_;

  modport master (
    output spm_addr, spm_as_, spm_rw, spm_wr_data,
    output bus_req_, bus_addr, bus_rw, bus_wr_data,
    input  spm_rd_data, spm_busy, bus_rd_data, bus_ack_
  );

  modport slave (
    input  spm_addr, spm_as_, spm_rw, spm_wr_data,
    input  bus_req_, bus_addr, bus_rw, bus_wr_data,
    output spm_rd_data, spm_busy, bus_rd_data, bus_ack_
  );
endinterface

// File: rtl/spm_ctrl_ram.sv
// Scratch-pad storage: two asynchronous read ports, one synchronous write port.
module spm_ctrl_ram
  import spm_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [DEPTH_LOG2-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_b
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Single write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/spm_ctrl.sv
// SPM responder: posted core writes through a 1-entry buffer, same-cycle
// core reads with buffer bypass, and a bus requester whose blocked writes
// eventually stall the core via spm_busy.
module spm_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  spm_ctrl_if.slave  spm
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  typedef logic [DEPTH_LOG2-1:0] idx_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(STARVE_LIMIT)) ? v : v + 1'b1;
  endfunction

  logic              wbuf_valid;
  idx_t              wbuf_addr;
  logic [DATA_W-1:0] wbuf_data;
  bus_state_t        state, state_next;
  logic [CNT_W-1:0]  starve_cnt, cnt_next;
  logic              busy;
  idx_t              bus_idx;
  logic              bus_rw_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] bus_rd_q;
  logic              bus_commit, bus_sample;
  logic              core_rd, core_wr;
  idx_t              core_idx;
  logic              ram_we;
  idx_t              ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rd_core, ram_rd_bus, bus_rd_byp;
  logic              unused_addr_hi;

  // Upper address bits alias onto the decoded range
  assign core_idx       = spm.spm_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^{spm.spm_addr[ADDR_W-1:DEPTH_LOG2], spm.bus_addr[ADDR_W-1:DEPTH_LOG2]};

  // Core accesses presented while stalled are ignored
  assign core_rd = !spm.spm_as_ && !busy && (spm.spm_rw == READ);
  assign core_wr = !spm.spm_as_ && !busy && (spm.spm_rw == WRITE);

  // A bus write only gets the port when the buffer is not draining
  assign bus_commit = (state == BUS_WAIT) && (bus_rw_q == WRITE) && !wbuf_valid;

  spm_ctrl_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (core_idx),
    .rdata_a (ram_rd_core),
    .raddr_b (bus_idx),
    .rdata_b (ram_rd_bus)
  );

  // Write-port arbitration: buffer drain first, then bus; nothing lands during reset
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wbuf_addr;
    ram_wdata = wbuf_data;
    if (reset) begin
      if (wbuf_valid) begin
        ram_we = 1'b1;
      end else if (bus_commit) begin
        ram_we    = 1'b1;
        ram_waddr = bus_idx;
        ram_wdata = bus_wdata_q;
      end
    end
  end

  // Core read data with write-buffer bypass; zero when no read is accepted
  always_comb begin
    spm.spm_rd_data = '0;
    if (core_rd) begin
      spm.spm_rd_data = (wbuf_valid && wbuf_addr == core_idx) ? wbuf_data : ram_rd_core;
    end
  end

  assign bus_rd_byp = (wbuf_valid && wbuf_addr == bus_idx) ? wbuf_data : ram_rd_bus;

  // Write-buffer occupancy; a pending entry is dropped on reset
  always_ff @(posedge clk) begin
    if (!reset) wbuf_valid <= 1'b0;
    else        wbuf_valid <= core_wr;
  end

  // Write-buffer payload
  always_ff @(posedge clk) begin
    if (core_wr) begin
      wbuf_addr <= core_idx;
      wbuf_data <= spm.spm_wr_data;
    end
  end

  // Bus FSM next state and starvation counter
  always_comb begin
    state_next = state;
    cnt_next   = starve_cnt;
    bus_sample = 1'b0;
    case (state)
      BUS_IDLE: begin
        cnt_next = '0;
        if (!spm.bus_req_) state_next = BUS_WAIT;
      end
      BUS_WAIT: begin
        if (bus_rw_q == READ) begin
          bus_sample = 1'b1;
          state_next = BUS_ACK;
          cnt_next   = '0;
        end else if (bus_commit) begin
          state_next = BUS_ACK;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(starve_cnt);
        end
      end
      BUS_ACK: begin
        state_next = BUS_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = BUS_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state, counter and stall request
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= BUS_IDLE;
      starve_cnt <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= cnt_next;
      busy       <= (cnt_next == CNT_W'(STARVE_LIMIT));
    end
  end

  // Bus request capture, taken only from IDLE
  always_ff @(posedge clk) begin
    if (state == BUS_IDLE && !spm.bus_req_) begin
      bus_idx     <= spm.bus_addr[DEPTH_LOG2-1:0];
      bus_rw_q    <= spm.bus_rw;
      bus_wdata_q <= spm.bus_wr_data;
    end
  end

  // Bus read data, held until the next bus read
  always_ff @(posedge clk) begin
    if (!reset)          bus_rd_q <= '0;
    else if (bus_sample) bus_rd_q <= bus_rd_byp;
  end

  assign spm.spm_busy    = busy;
  assign spm.bus_ack_    = (state == BUS_ACK) ? 1'b0 : 1'b1;
  assign spm.bus_rd_data = bus_rd_q;
endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl: memory reference model, scoreboard queues, directed
// scenarios followed by randomized core/bus traffic.
module tb_spm_ctrl;
  import spm_ctrl_pkg::*;

  localparam int DEPTH_LOG2   = 12;
  localparam int STARVE_LIMIT = 4;
  localparam int SPAN         = 128;

  typedef struct {
    logic              is_read;
    logic [DATA_W-1:0] data;
    int                due;
  } bus_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spm_ctrl_if sif();

  spm_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .spm   (sif.slave)
  );

  logic [DATA_W-1:0] model [SPAN];
  logic [DATA_W-1:0] core_q [$];
  bus_exp_t          bus_q [$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic mon_on = 1'b0;

  logic              req_new = 1'b0;
  logic              req_rw_n;
  logic [ADDR_W-1:0] req_addr_n;
  logic [DATA_W-1:0] req_data_n;
  logic              pend = 1'b0;
  logic              pend_rw;
  int                pend_idx;
  logic [DATA_W-1:0] pend_data;
  int                req_cyc;
  int                last_ack = -1;
  logic              prev_wr = 1'b0;
  int                prev_idx;
  logic [DATA_W-1:0] prev_old;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input int idx);
    return ADDR_W'(idx) | (ADDR_W'($urandom_range(0, 3)) << DEPTH_LOG2);
  endfunction

  task automatic bus_req(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    req_new    = 1'b1;
    req_rw_n   = rw;
    req_addr_n = addr;
    req_data_n = data;
  endtask

  // One clock: update the model from what the spec says happened, then drive
  task automatic step(input logic as_, input logic rw, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data);
    logic busy_now;
    int   idx;
    @(posedge clk);
    #1;
    cyc++;
    busy_now = sif.spm_busy;
    idx      = int'(addr[DEPTH_LOG2-1:0]);
    if (!reset) begin
      if (prev_wr) model[prev_idx] = prev_old;
      prev_wr = 1'b0;
      pend    = 1'b0;
      req_new = 1'b0;
      bus_q.delete();
      sif.bus_req_    = 1'b1;
      sif.spm_as_     = 1'b1;
      sif.spm_rw      = READ;
      sif.spm_addr    = addr;
      sif.spm_wr_data = data;
    end else begin
      if (pend && sif.bus_ack_ == 1'b0) begin
        if (pend_rw == WRITE) model[pend_idx] = pend_data;
        pend         = 1'b0;
        last_ack     = cyc;
        sif.bus_req_ = 1'b1;
      end
      if (pend && pend_rw == READ && cyc == req_cyc + 1)
        bus_q.push_back('{is_read: 1'b1, data: model[pend_idx], due: req_cyc + 2});
      if (pend && cyc - req_cyc > STARVE_LIMIT + 10) begin
        n_chk++;
        n_fail++;
        $display("FAIL bus_ack_timeout: no ack after %0d cycles, required within %0d", cyc - req_cyc, STARVE_LIMIT + 10);
        pend         = 1'b0;
        sif.bus_req_ = 1'b1;
        bus_q.delete();
      end
      if (req_new && !pend && cyc > last_ack) begin
        sif.bus_req_     = 1'b0;
        sif.bus_rw       = req_rw_n;
        sif.bus_addr     = req_addr_n;
        sif.bus_wr_data  = req_data_n;
        pend      = 1'b1;
        pend_rw   = req_rw_n;
        pend_idx  = int'(req_addr_n[DEPTH_LOG2-1:0]);
        pend_data = req_data_n;
        req_cyc   = cyc;
        req_new   = 1'b0;
        if (req_rw_n == WRITE) bus_q.push_back('{is_read: 1'b0, data: '0, due: -1});
      end
      sif.spm_as_     = as_;
      sif.spm_rw      = rw;
      sif.spm_addr    = addr;
      sif.spm_wr_data = data;
      prev_wr = 1'b0;
      if (!as_) begin
        if (rw == READ) begin
          core_q.push_back(busy_now ? '0 : model[idx]);
        end else if (!busy_now) begin
          prev_wr  = 1'b1;
          prev_idx = idx;
          prev_old = model[idx];
          model[idx] = data;
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b1, READ, '0, '0);
  endtask

  task automatic wait_bus();
    for (int i = 0; i < 40 && (pend || req_new); i++) idle();
    if (pend || req_new) begin
      n_chk++;
      n_fail++;
      $display("FAIL bus_wait: transaction still open, required complete");
      pend = 1'b0;
      req_new = 1'b0;
      sif.bus_req_ = 1'b1;
    end
  endtask

  bus_exp_t          mon_e;
  logic [DATA_W-1:0] mon_c;

  // Monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    if (mon_on) begin
      if (!sif.spm_as_ && sif.spm_rw == READ) begin
        if (core_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL core_rd_unexpected: got %h with empty scoreboard", sif.spm_rd_data);
        end else begin
          mon_c = core_q.pop_front();
          chk("core_rd", sif.spm_rd_data, mon_c);
        end
      end else begin
        chk("core_rd_idle", sif.spm_rd_data, '0);
      end
      if (sif.bus_ack_ == 1'b0) begin
        if (bus_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL bus_ack_unexpected: ack low with no outstanding request");
        end else begin
          mon_e = bus_q.pop_front();
          if (mon_e.is_read) begin
            chk("bus_rd", sif.bus_rd_data, mon_e.data);
            chk("bus_rd_latency", 32'(cyc), 32'(mon_e.due));
          end
        end
      end
    end
  end

  int r;

  initial begin
    sif.spm_as_     = 1'b1;
    sif.spm_rw      = READ;
    sif.spm_addr    = '0;
    sif.spm_wr_data = '0;
    sif.bus_req_    = 1'b1;
    sif.bus_rw      = READ;
    sif.bus_addr    = '0;
    sif.bus_wr_data = '0;
    for (int i = 0; i < SPAN; i++) model[i] = '0;

    reset = 1'b0;
    repeat (3) idle();
    mon_on = 1'b1;
    chk("rst_ack", 32'(sif.bus_ack_), 32'd1);
    chk("rst_busy", 32'(sif.spm_busy), 32'd0);
    chk("rst_bus_rd", sif.bus_rd_data, '0);
    reset = 1'b1;

    for (int i = 0; i < SPAN; i++) step(1'b0, WRITE, ADDR_W'(i), $urandom);
    repeat (2) idle();

    // Write then bypass read, then array read
    step(1'b0, WRITE, 30'h10, 32'hDEADBEEF);
    step(1'b0, READ, 30'h10, '0);
    repeat (2) idle();
    step(1'b0, READ, 30'h10, '0);
    chk("t1_model", model[16], 32'hDEADBEEF);

    // Back-to-back writes never stall
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, WRITE, ADDR_W'(i), 32'hA + DATA_W'(i - 1));
      chk("t2_busy_wr", 32'(sif.spm_busy), 32'd0);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, READ, ADDR_W'(i), '0);
      chk("t2_busy_rd", 32'(sif.spm_busy), 32'd0);
    end

    // Bus read: ack two cycles after the request, one cycle wide
    step(1'b0, WRITE, 30'h20, 32'h12345678);
    repeat (2) idle();
    bus_req(READ, 30'h20, '0);
    idle();
    r = cyc;
    for (int k = 1; k <= 3; k++) begin
      idle();
      chk("t3_ack", 32'(sif.bus_ack_), (k == 2) ? 32'd0 : 32'd1);
    end

    // Starved bus write against continuous core writes
    bus_req(WRITE, 30'h40, 32'h55);
    for (int k = 0; k <= 7; k++) begin
      step(1'b0, WRITE, 30'h41 + ADDR_W'(k), 32'h100 + DATA_W'(k));
      chk("t4_busy", 32'(sif.spm_busy), (k == 5 || k == 6) ? 32'd1 : 32'd0);
      chk("t4_ack", 32'(sif.bus_ack_), (k == 7) ? 32'd0 : 32'd1);
    end
    idle();
    step(1'b0, READ, 30'h40, '0);
    step(1'b0, READ, 30'h46, '0);
    step(1'b0, READ, 30'h47, '0);
    step(1'b0, READ, 30'h48, '0);

    // Reset discards a buffered write
    step(1'b0, WRITE, 30'h30, 32'h11);
    repeat (2) idle();
    step(1'b0, WRITE, 30'h30, 32'h99);
    reset = 1'b0;
    idle();
    reset = 1'b1;
    idle();
    chk("t5_ack", 32'(sif.bus_ack_), 32'd1);
    chk("t5_busy", 32'(sif.spm_busy), 32'd0);
    chk("t5_bus_rd", sif.bus_rd_data, '0);
    step(1'b0, READ, 30'h30, '0);

    // Same-address core and bus writes; bus read through the bypass
    bus_req(WRITE, 30'h50, 32'h2);
    step(1'b0, WRITE, 30'h50, 32'h1);
    wait_bus();
    idle();
    step(1'b0, READ, 30'h50, '0);
    bus_req(READ, 30'h60, '0);
    step(1'b0, WRITE, 30'h60, 32'h7);
    wait_bus();
    idle();

    // Randomized mixed traffic
    repeat (400) begin
      int idx;
      int op;
      if (!pend && !req_new && $urandom_range(0, 3) == 0)
        bus_req(1'($urandom_range(0, 1)), mk_addr($urandom_range(0, SPAN - 1)), $urandom);
      idx = $urandom_range(0, SPAN - 1);
      op  = $urandom_range(0, 2);
      if (op == 1 && pend && pend_rw == WRITE && idx == pend_idx) op = 0;
      if (op == 0)      step(1'b0, READ, mk_addr(idx), '0);
      else if (op == 1) step(1'b0, WRITE, mk_addr(idx), $urandom);
      else              idle();
    end
    wait_bus();
    repeat (2) idle();
    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    chk("core_q_left", 32'(core_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
